// File: rtl/hpi_responder_pkg.sv
// Shared register-select codes and STATUS layout for the HPI responder.
package hpi_pkg;

  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  localparam int STAT_HOST_BIT = 0;  // initiator mailbox still unacknowledged
  localparam int STAT_RESP_BIT = 1;  // reply word waiting for the initiator

  // Assemble the STATUS register image from the two mailbox flags.
  function automatic logic [15:0] status_word(input logic resp_full, input logic host_valid);
    logic [15:0] s;
    s = '0;
    s[STAT_RESP_BIT] = resp_full;
    s[STAT_HOST_BIT] = host_valid;
    return s;
  endfunction

endpackage

// File: rtl/hpi_responder_if.sv
// HPI bus as seen between the initiator (PIO exports) and the responder.
interface hpi_responder_if;
  logic [1:0]  otg_hpi_address;
  logic        otg_hpi_cs;
  logic        otg_hpi_r;
  logic        otg_hpi_w;
  logic        otg_hpi_reset;
  logic [15:0] otg_hpi_data_in;
  logic [15:0] otg_hpi_data_out;

  modport master (
    output otg_hpi_address, otg_hpi_cs, otg_hpi_r, otg_hpi_w, otg_hpi_reset, otg_hpi_data_in,
    input  otg_hpi_data_out
  );

  modport slave (
    input  otg_hpi_address, otg_hpi_cs, otg_hpi_r, otg_hpi_w, otg_hpi_reset, otg_hpi_data_in,
    output otg_hpi_data_out
  );
endinterface

// File: rtl/hpi_responder_word_ram.sv
// Emulated chip memory: one synchronous write port, asynchronous read, no reset.
module hpi_word_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [DEPTH];

  // Single write port; the caller has already arbitrated HPI against the injector.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hpi_responder.sv
// Responder end of the OTG HPI port: emulates the host-port register file
// (DATA/MAILBOX/ADDRESS/STATUS) over a local word RAM with a preload injector.
module hpi_responder
  import hpi_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  hpi_responder_if.slave  hpi,
  input  logic            inj_valid,
  output logic            inj_ready,
  input  logic [AW-1:0]   inj_addr,
  input  logic [15:0]     inj_data,
  output logic            host_mbx_valid,
  output logic [15:0]     host_mbx_data,
  input  logic            host_mbx_ack,
  input  logic            resp_mbx_valid,
  input  logic [15:0]     resp_mbx_data
);

  // Strobe history. Reset to "asserted" so a strobe already low when reset
  // releases is treated as old and never commits.
  logic r_q, w_q;

  logic [AW:0]  ptr_q,       ptr_d;
  logic [15:0]  data_out_q,  data_out_d;
  logic         host_valid_q, host_valid_d;
  logic [15:0]  host_data_q, host_data_d;
  logic         resp_full_q, resp_full_d;
  logic [15:0]  resp_word_q, resp_word_d;

  logic         soft_rst;
  logic         both_low;
  logic         rd_fire, wr_fire;
  logic         wr_data;
  logic         ram_we;
  logic [AW-1:0] ram_waddr;
  logic [15:0]  ram_wdata;
  logic [15:0]  ram_rdata;

  assign soft_rst = ~hpi.otg_hpi_reset;
  assign both_low = ~hpi.otg_hpi_r & ~hpi.otg_hpi_w;
  assign rd_fire  = ~hpi.otg_hpi_r & r_q & ~hpi.otg_hpi_cs & ~both_low & ~soft_rst;
  assign wr_fire  = ~hpi.otg_hpi_w & w_q & ~hpi.otg_hpi_cs & ~both_low & ~soft_rst;

  // HPI DATA writes own the RAM port for their commit cycle; the injector holds and retries.
  assign wr_data   = wr_fire & (hpi.otg_hpi_address == HPI_DATA);
  assign inj_ready = ~wr_data;
  assign ram_we    = wr_data | inj_valid;
  assign ram_waddr = wr_data ? ptr_q[AW:1] : inj_addr;
  assign ram_wdata = wr_data ? hpi.otg_hpi_data_in : inj_data;

  hpi_word_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (clk_clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ptr_q[AW:1]),
    .rdata_o (ram_rdata)
  );

  // Register-file next state: mailbox events first, then HPI commits, soft reset last so it wins.
  always_comb begin
    ptr_d        = ptr_q;
    data_out_d   = data_out_q;
    host_valid_d = host_valid_q;
    host_data_d  = host_data_q;
    resp_full_d  = resp_full_q;
    resp_word_d  = resp_word_q;

    if (resp_mbx_valid) begin
      resp_word_d = resp_mbx_data;
      resp_full_d = 1'b1;
    end
    if (host_mbx_ack) host_valid_d = 1'b0;

    if (wr_fire) begin
      unique case (hpi.otg_hpi_address)
        HPI_ADDRESS: ptr_d = hpi.otg_hpi_data_in[AW:0];
        HPI_DATA:    ptr_d = ptr_q + (AW+1)'(2);
        HPI_MAILBOX: begin
          host_data_d  = hpi.otg_hpi_data_in;
          host_valid_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (rd_fire) begin
      unique case (hpi.otg_hpi_address)
        HPI_DATA: begin
          data_out_d = ram_rdata;
          ptr_d      = ptr_q + (AW+1)'(2);
        end
        HPI_MAILBOX: begin
          // A reply posted in the same cycle is newer than the word being read, so the flag stays set.
          data_out_d = resp_word_q;
          if (!resp_mbx_valid) resp_full_d = 1'b0;
        end
        HPI_ADDRESS: data_out_d = {{(15-AW){1'b0}}, ptr_q};
        default:     data_out_d = status_word(resp_full_q, host_valid_q);
      endcase
    end

    if (soft_rst) begin
      ptr_d        = '0;
      data_out_d   = '0;
      host_valid_d = 1'b0;
      resp_full_d  = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_q          <= 1'b0;
      w_q          <= 1'b0;
      ptr_q        <= '0;
      data_out_q   <= '0;
      host_valid_q <= 1'b0;
      host_data_q  <= '0;
      resp_full_q  <= 1'b0;
      resp_word_q  <= '0;
    end else begin
      r_q          <= hpi.otg_hpi_r;
      w_q          <= hpi.otg_hpi_w;
      ptr_q        <= ptr_d;
      data_out_q   <= data_out_d;
      host_valid_q <= host_valid_d;
      host_data_q  <= host_data_d;
      resp_full_q  <= resp_full_d;
      resp_word_q  <= resp_word_d;
    end
  end

  assign hpi.otg_hpi_data_out = data_out_q;
  assign host_mbx_valid       = host_valid_q;
  assign host_mbx_data        = host_data_q;

endmodule
